// File: rtl/scene_pkg.sv
// Shared definitions for the scene entry table: default geometry,
// light entry field layout and the commit engine state encoding.
package scene_pkg;

  localparam int DEF_ENTRY_W  = 192;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_RD_PORTS = 2;

  // Light entry: Q8.24 x3 position in the low half, Q8.24 x3 colour above it.
  localparam int FIELD_W = 96;
  localparam int POS_LSB = 0;
  localparam int POS_MSB = 95;
  localparam int COL_LSB = 96;
  localparam int COL_MSB = 191;

  typedef struct packed {
    logic [FIELD_W-1:0] col;
    logic [FIELD_W-1:0] pos;
  } light_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } commit_state_e;

endpackage

// File: rtl/table_ram.sv
// Single-write, single-registered-read table; reads return the pre-write
// contents when the same entry is written on the same edge.
module table_ram
  import scene_pkg::*;
#(
  parameter int  ENTRY_W = DEF_ENTRY_W,
  parameter int  DEPTH   = DEF_DEPTH,
  localparam int ID_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ID_W-1:0]    waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ID_W-1:0]    raddr,
  output logic [ENTRY_W-1:0] rdata
);

  // Contents power up cleared and are deliberately untouched by rst.
  logic [ENTRY_W-1:0] mem [DEPTH] = '{default: '0};

  logic [ENTRY_W-1:0] rdata_d;
  logic [ENTRY_W-1:0] rdata_q;

  always_comb begin
    rdata_d = '0;
    if (int'(raddr) < DEPTH) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scene_entry_table.sv
// Double-buffered scene table: host fills staging, a commit engine copies a
// prefix of it into per-port active replicas that the tracers read.
module scene_entry_table
  import scene_pkg::*;
#(
  parameter int  ENTRY_W  = DEF_ENTRY_W,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  RD_PORTS = DEF_RD_PORTS,
  localparam int ID_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stage_we,
  input  logic [ID_W-1:0]             stage_id,
  input  logic [ENTRY_W-1:0]          stage_data,
  input  logic                        commit_req,
  input  logic [ID_W:0]               commit_len,
  output logic                        commit_busy,
  output logic                        commit_done,
  output logic [ID_W:0]               active_count,
  input  logic [RD_PORTS*ID_W-1:0]    rd_id,
  output logic [RD_PORTS*ENTRY_W-1:0] rd_data
);

  localparam int LEN_W = ID_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  commit_state_e     state_d, state_q;
  logic [LEN_W-1:0]  len_d, len_q;
  logic [LEN_W-1:0]  remain_d, remain_q;
  logic [ID_W-1:0]   rd_idx_d, rd_idx_q;
  logic              wr_en_d, wr_en_q;
  logic [ID_W-1:0]   wr_idx_d, wr_idx_q;
  logic              done_d, done_q;
  logic [LEN_W-1:0]  count_d, count_q;

  logic [LEN_W-1:0]  len_clamped;
  logic [ENTRY_W-1:0] stage_rdata;

  assign len_clamped = (commit_len > DEPTH_LEN) ? DEPTH_LEN : commit_len;

  // remain_q counts staging reads still to issue; reaching zero in COPY means
  // the last read is already in flight and its write lands this cycle.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    remain_d = remain_q;
    rd_idx_d = rd_idx_q;
    wr_en_d  = 1'b0;
    wr_idx_d = wr_idx_q;
    done_d   = 1'b0;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          state_d  = ST_COPY;
          len_d    = len_clamped;
          remain_d = len_clamped;
          rd_idx_d = '0;
        end
      end
      ST_COPY: begin
        if (remain_q != '0) begin
          wr_en_d  = 1'b1;
          wr_idx_d = rd_idx_q;
          rd_idx_d = rd_idx_q + ID_W'(1);
          remain_d = remain_q - LEN_W'(1);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          count_d = len_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      remain_q <= '0;
      rd_idx_q <= '0;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      remain_q <= remain_d;
      rd_idx_q <= rd_idx_d;
      wr_en_q  <= wr_en_d;
      wr_idx_q <= wr_idx_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign commit_busy  = (state_q == ST_COPY);
  assign commit_done  = done_q;
  assign active_count = count_q;

  table_ram #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_staging (
    .clk   (clk),
    .rst   (rst),
    .we    (stage_we & ~rst),
    .waddr (stage_id),
    .wdata (stage_data),
    .raddr (rd_idx_q),
    .rdata (stage_rdata)
  );

  // A write already in flight when rst arrives still completes; rst only
  // stops further copy traffic.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_active
    table_ram #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH)
    ) u_active (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en_q),
      .waddr (wr_idx_q),
      .wdata (stage_rdata),
      .raddr (rd_id[p*ID_W +: ID_W]),
      .rdata (rd_data[p*ENTRY_W +: ENTRY_W])
    );
  end

endmodule

// File: tb/tb_scene_entry_table.sv
// Directed bench for scene_entry_table: a cycle-timed model of the commit
// schedule is checked every cycle, plus hand-computed pinned expectations.
module tb_scene_entry_table;

  localparam int ENTRY_W  = 192;
  localparam int DEPTH    = 8;
  localparam int RD_PORTS = 2;
  localparam int ID_W     = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        stage_we;
  logic [ID_W-1:0]             stage_id;
  logic [ENTRY_W-1:0]          stage_data;
  logic                        commit_req;
  logic [ID_W:0]               commit_len;
  logic                        commit_busy;
  logic                        commit_done;
  logic [ID_W:0]               active_count;
  logic [RD_PORTS*ID_W-1:0]    rd_id;
  logic [RD_PORTS*ENTRY_W-1:0] rd_data;

  scene_entry_table #(
    .ENTRY_W  (ENTRY_W),
    .DEPTH    (DEPTH),
    .RD_PORTS (RD_PORTS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stage_we     (stage_we),
    .stage_id     (stage_id),
    .stage_data   (stage_data),
    .commit_req   (commit_req),
    .commit_len   (commit_len),
    .commit_busy  (commit_busy),
    .commit_done  (commit_done),
    .active_count (active_count),
    .rd_id        (rd_id),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit chk_en       = 0;

  task automatic chk(string name, logic [ENTRY_W-1:0] got, logic [ENTRY_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] pat(int gen, int idx);
    logic [31:0] w;
    w = 32'h5CE0_0000 | 32'(gen << 8) | 32'(idx);
    return {w ^ 32'h1111_1111, w, w ^ 32'h2222_2222, ~w, w ^ 32'h3333_3333, w};
  endfunction

  // Model: time-stamped commit (accepted at ct, length cl). Entry k is
  // snapshotted from staging at ct+1+k and lands in active at ct+2+k.
  logic [ENTRY_W-1:0] stage_m  [DEPTH];
  logic [ENTRY_W-1:0] active_m [DEPTH];
  logic [ENTRY_W-1:0] snap_m   [DEPTH];
  logic [ENTRY_W-1:0] rd_e     [RD_PORTS];
  bit c_on, busy_e, done_e, cur_busy;
  int ct, cl, count_e;

  initial begin
    int n, kr, kw, id;
    for (int i = 0; i < DEPTH; i++) begin
      stage_m[i] = '0; active_m[i] = '0; snap_m[i] = '0;
    end
    for (int p = 0; p < RD_PORTS; p++) rd_e[p] = '0;
    c_on = 0; busy_e = 0; done_e = 0; ct = 0; cl = 0; count_e = 0;
    forever begin
      @(posedge clk);
      n = cyc;
      cur_busy = busy_e;
      for (int p = 0; p < RD_PORTS; p++) begin
        id = int'(rd_id[p*ID_W +: ID_W]);
        rd_e[p] = (rst || id >= DEPTH) ? '0 : active_m[id];
      end
      if (c_on) begin
        kr = n - (ct + 1);
        kw = n - (ct + 2);
        if (kw >= 0 && kw < cl) active_m[kw] = snap_m[kw];
        if (!rst && kr >= 0 && kr < cl) snap_m[kr] = stage_m[kr];
      end
      if (!rst && stage_we && int'(stage_id) < DEPTH) stage_m[stage_id] = stage_data;
      if (rst) begin
        c_on = 0; busy_e = 0; done_e = 0; count_e = 0;
        chk_en = 1;
      end else begin
        done_e = c_on && (n + 1 == ct + cl + 2);
        if (done_e) begin
          count_e = cl;
          c_on = 0;
        end
        if (commit_req && !cur_busy) begin
          ct = n;
          cl = (int'(commit_len) > DEPTH) ? DEPTH : int'(commit_len);
          c_on = 1;
        end
        busy_e = c_on && (n + 1 <= ct + cl + 1);
      end
      cyc = cyc + 1;
      #1;
      if (chk_en) begin
        chk("model_busy",  ENTRY_W'(commit_busy),  ENTRY_W'(busy_e));
        chk("model_done",  ENTRY_W'(commit_done),  ENTRY_W'(done_e));
        chk("model_count", ENTRY_W'(active_count), ENTRY_W'(count_e));
        for (int p = 0; p < RD_PORTS; p++)
          chk("model_rd_data", rd_data[p*ENTRY_W +: ENTRY_W], rd_e[p]);
      end
    end
  end

  logic [ENTRY_W-1:0] exp_tab [DEPTH];

  task automatic stage_write(int id, logic [ENTRY_W-1:0] d);
    stage_we = 1'b1; stage_id = ID_W'(id); stage_data = d;
    @(negedge clk);
    stage_we = 1'b0;
  endtask

  task automatic start_commit(int len, output int t);
    commit_req = 1'b1; commit_len = (ID_W+1)'(len); t = cyc;
    @(negedge clk);
    commit_req = 1'b0;
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(string name, output int dc);
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      if (commit_done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dc < 0) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: no commit_done within 40 cycles", name);
    end
  endtask

  // Port 0 walks 0..7, port 1 walks 7..0.
  task automatic read_all(string name);
    for (int i = 0; i < DEPTH; i++) begin
      rd_id = {ID_W'(DEPTH - 1 - i), ID_W'(i)};
      @(negedge clk);
      chk({name, "_p0"}, rd_data[0 +: ENTRY_W], exp_tab[i]);
      chk({name, "_p1"}, rd_data[ENTRY_W +: ENTRY_W], exp_tab[DEPTH - 1 - i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, dc, pulses;
    rst = 1'b1; stage_we = 1'b0; stage_id = '0; stage_data = '0;
    commit_req = 1'b0; commit_len = '0; rd_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  ENTRY_W'(commit_busy),  '0);
    chk("rst_done",  ENTRY_W'(commit_done),  '0);
    chk("rst_count", ENTRY_W'(active_count), '0);
    chk("rst_rd",    ENTRY_W'(rd_data[0 +: ENTRY_W]), '0);
    rst = 1'b0;

    // Staging writes stay invisible to tracers without a commit.
    for (int i = 0; i < DEPTH; i++) stage_write(i, pat(1, i));
    for (int i = 0; i < DEPTH; i++) exp_tab[i] = '0;
    read_all("no_commit");
    chk("no_commit_count", ENTRY_W'(active_count), '0);

    // Full commit: busy t+1..t+9, done at t+10.
    start_commit(8, t);
    chk("full_busy_t1", ENTRY_W'(commit_busy), 1);
    wait_done("full_done", dc);
    chk("full_done_lat", ENTRY_W'(dc - t), 10);
    chk("full_count", ENTRY_W'(active_count), 8);
    @(negedge clk);
    chk("full_done_once", ENTRY_W'(commit_done), 0);
    for (int i = 0; i < DEPTH; i++) exp_tab[i] = pat(1, i);
    read_all("full");

    // Partial commit of 3 entries over new staging contents.
    for (int i = 0; i < DEPTH; i++) stage_write(i, pat(2, i));
    start_commit(3, t);
    wait_done("part_done", dc);
    chk("part_done_lat", ENTRY_W'(dc - t), 5);
    chk("part_count", ENTRY_W'(active_count), 3);
    for (int i = 0; i < DEPTH; i++) exp_tab[i] = (i < 3) ? pat(2, i) : pat(1, i);
    read_all("part");

    // Staging write to entry 5 in the very cycle entry 5 is read.
    start_commit(8, t);
    wait_cyc(t + 6);
    stage_write(5, pat(3, 5));
    wait_done("mid_done", dc);
    for (int i = 0; i < DEPTH; i++) exp_tab[i] = pat(2, i);
    read_all("mid_write");

    // Recommit with a staging write in the same cycle as the request.
    commit_req = 1'b1; commit_len = 4'd8;
    stage_we = 1'b1; stage_id = 3'd0; stage_data = pat(4, 0);
    t = cyc;
    @(negedge clk);
    commit_req = 1'b0; stage_we = 1'b0;
    wait_done("recommit_done", dc);
    chk("recommit_done_lat", ENTRY_W'(dc - t), 10);
    exp_tab[0] = pat(4, 0);
    exp_tab[5] = pat(3, 5);
    read_all("recommit");

    // A second request while busy is dropped: exactly one done pulse.
    start_commit(8, t);
    wait_cyc(t + 3);
    commit_req = 1'b1; commit_len = 4'd2;
    @(negedge clk);
    commit_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (commit_done) pulses++;
      @(negedge clk);
    end
    chk("busy_req_pulses", ENTRY_W'(pulses), 1);
    chk("busy_req_count",  ENTRY_W'(active_count), 8);

    // Zero-length commit.
    start_commit(0, t);
    chk("zero_busy_t1", ENTRY_W'(commit_busy), 1);
    wait_done("zero_done", dc);
    chk("zero_done_lat", ENTRY_W'(dc - t), 2);
    chk("zero_count", ENTRY_W'(active_count), 0);
    read_all("zero");

    // Oversized length clamps to DEPTH.
    start_commit(12, t);
    wait_done("clamp_done", dc);
    chk("clamp_done_lat", ENTRY_W'(dc - t), 10);
    chk("clamp_count", ENTRY_W'(active_count), 8);

    // Reset mid-copy: entries 0..2 land, the rest keep their old values.
    for (int i = 0; i < DEPTH; i++) stage_write(i, pat(5, i));
    start_commit(8, t);
    wait_cyc(t + 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  ENTRY_W'(commit_busy),  0);
    chk("abort_count", ENTRY_W'(active_count), 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (commit_done) pulses++;
      @(negedge clk);
    end
    chk("abort_no_done", ENTRY_W'(pulses), 0);
    chk("abort_count_after", ENTRY_W'(active_count), 0);
    for (int i = 0; i < 3; i++) exp_tab[i] = pat(5, i);
    read_all("abort");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
